// File: rtl/matvec_ctrl.sv
// Sequencer for the matvec_mul datapath: owns the weight bank, gates the datapath clock
// enable and tracks in-flight vectors so y leaves through a valid/ready port.
module matvec_ctrl #(
    parameter  int R   = 8,
    parameter  int C   = 8,
    parameter  int W_X = 8,
    parameter  int W_K = 8,
    localparam int LAT = $clog2(C) + 1,
    localparam int W_Y = W_X + W_K + $clog2(C),
    localparam int RW  = (R > 1) ? $clog2(R) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 k_valid,
    output logic                 k_ready,
    input  logic [RW-1:0]        k_row,
    input  logic [C*W_K-1:0]     k_data,
    input  logic                 k_last,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [C*W_X-1:0]     s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [R*W_Y-1:0]     m_data,
    output logic                 mv_cen,
    output logic [R*C*W_K-1:0]   mv_k,
    output logic [C*W_X-1:0]     mv_x,
    input  logic [R*W_Y-1:0]     mv_y,
    output logic                 busy,
    output logic                 err_row
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [C*W_K-1:0] bank [R];
    logic [LAT-1:0]   vld;
    logic             stall;
    logic             s_fire;
    logic             k_fire;
    logic             row_ok;
    logic [31:0]      row_idx;

    assign m_valid = vld[LAT-1];
    assign stall   = m_valid & ~m_ready;
    assign mv_cen  = ~stall;
    assign s_fire  = s_valid & s_ready;
    assign k_fire  = k_valid & k_ready;
    assign busy    = |vld;
    assign mv_x    = s_data;
    assign m_data  = mv_y;

    // Widened so row indices beyond R are caught even when R is not a power of two.
    assign row_idx = 32'(k_row);
    assign row_ok  = row_idx < 32'(R);

    for (genvar g = 0; g < R; g++) begin : g_mvk
        assign mv_k[g*C*W_K +: C*W_K] = bank[g];
    end

    always_comb begin
        state_nxt = state;
        k_ready   = 1'b0;
        s_ready   = 1'b0;
        case (state)
            S_LOAD: begin
                k_ready = 1'b1;
                if (k_valid && k_last) state_nxt = S_RUN;
            end
            S_RUN: begin
                s_ready = mv_cen;
                if (k_valid) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (vld == '0) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_LOAD;
            vld     <= '0;
            err_row <= 1'b0;
        end else begin
            state <= state_nxt;
            // Tracker advances in lockstep with the datapath so m_valid marks its output.
            if (mv_cen) vld <= LAT'({vld, s_fire});
            if (k_fire && !row_ok) err_row <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned r = 0; r < R; r++) bank[r] <= '0;
        end else if (k_fire && row_ok) begin
            bank[k_row] <= k_data;
        end
    end

endmodule
